// File: rtl/ahb_prio_arbiter.sv
// AHB priority arbiter: fixed-priority grant with burst tracking and locked-transfer hold.
// Optional macro AHB_ARB_RR_EN turns priority ties into round-robin instead of lowest-index.
module ahb_prio_arbiter #(
    parameter int MAS_NUM = 4,
    parameter int PRIO_W  = 2
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [MAS_NUM-1:0]        hbusreq,
    input  logic [MAS_NUM-1:0]        hlock,
    input  logic [MAS_NUM*PRIO_W-1:0] hprior,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hburst,
    input  logic                      hready,
    output logic [MAS_NUM-1:0]        hgrant,
    output logic [$clog2(MAS_NUM)-1:0] hmaster,
    output logic                      hmastlock
);
    localparam int IDX_W = $clog2(MAS_NUM);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [MAS_NUM-1:0] GRANT_M0 = {{(MAS_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_PARK   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_BURST  = 2'd2,
        ST_LOCKED = 2'd3
    } state_t;

    state_t             r_state;
    logic [MAS_NUM-1:0] r_grant;
    logic [IDX_W-1:0]   r_hmaster;
    logic               r_mastlock;
    logic [3:0]         r_burst_cnt;
`ifdef AHB_ARB_RR_EN
    logic [IDX_W-1:0]   r_rr_ptr;
`endif

    logic [IDX_W-1:0]   w_own_idx;
    logic               w_own_lock;
    logic [PRIO_W-1:0]  w_prio [MAS_NUM];
    logic [IDX_W-1:0]   w_scan [MAS_NUM];
    logic               w_any_req;
    logic [IDX_W-1:0]   w_win_idx;
    logic [PRIO_W-1:0]  w_win_prio;
    logic [MAS_NUM-1:0] w_win_onehot;
    logic [3:0]         w_burst_len;
    logic               w_open;

    // Owner index from the one-hot grant, and that owner's lock request.
    always_comb begin
        w_own_idx = '0;
        for (int i = 0; i < MAS_NUM; i++) begin
            w_own_idx = w_own_idx | (r_grant[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        w_own_lock = hlock[w_own_idx];
    end

    // Scan order for the priority search; the first strictly-higher candidate wins ties.
    always_comb begin
        for (int k = 0; k < MAS_NUM; k++) begin
            w_prio[k] = hprior[k*PRIO_W +: PRIO_W];
`ifdef AHB_ARB_RR_EN
            w_scan[k] = IDX_W'((int'(r_rr_ptr) + 1 + k) % MAS_NUM);
`else
            w_scan[k] = IDX_W'(k);
`endif
        end
    end

    // Highest-priority requester search.
    always_comb begin
        w_any_req  = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int k = 0; k < MAS_NUM; k++) begin
            if (hbusreq[w_scan[k]] && (!w_any_req || (w_prio[w_scan[k]] > w_win_prio))) begin
                w_any_req  = 1'b1;
                w_win_idx  = w_scan[k];
                w_win_prio = w_prio[w_scan[k]];
            end else begin
                w_any_req  = w_any_req;
            end
        end
        w_win_onehot = GRANT_M0 << w_win_idx;
    end

    // Remaining-beat preload for fixed-length bursts; zero means no burst tracking.
    always_comb begin
        case (hburst)
            3'd2, 3'd3: w_burst_len = 4'd3;
            3'd4, 3'd5: w_burst_len = 4'd7;
            3'd6, 3'd7: w_burst_len = 4'd15;
            default:    w_burst_len = 4'd0;
        endcase
    end

    // Decide whether this edge re-arbitrates; a held lock always blocks it.
    always_comb begin
        case (r_state)
            ST_PARK:   w_open = ~w_own_lock;
            ST_GRANT:  w_open = ~w_own_lock & ~((htrans == TR_NONSEQ) && (w_burst_len != 4'd0));
            ST_BURST:  w_open = ~w_own_lock & (((htrans == TR_SEQ) && (r_burst_cnt == 4'd1)) ||
                                               (htrans == TR_IDLE) || (htrans == TR_NONSEQ));
            ST_LOCKED: w_open = ~w_own_lock;
            default:   w_open = 1'b0;
        endcase
    end

    // Arbiter FSM with registered grant, owner index and lock outputs.
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            r_state     <= ST_PARK;
            r_grant     <= GRANT_M0;
            r_hmaster   <= '0;
            r_mastlock  <= 1'b0;
            r_burst_cnt <= 4'd0;
`ifdef AHB_ARB_RR_EN
            r_rr_ptr    <= '0;
`endif
        end else if (hready) begin
            r_hmaster  <= w_own_idx;
            r_mastlock <= w_own_lock;
            if (w_own_lock) begin
                r_state     <= ST_LOCKED;
                r_burst_cnt <= 4'd0;
            end else if (w_open) begin
                r_burst_cnt <= 4'd0;
                if (w_any_req) begin
                    r_grant <= w_win_onehot;
                    r_state <= ST_GRANT;
`ifdef AHB_ARB_RR_EN
                    r_rr_ptr <= w_win_idx;
`endif
                end else begin
                    r_grant <= GRANT_M0;
                    r_state <= ST_PARK;
                end
            end else begin
                case (r_state)
                    ST_GRANT: begin
                        r_state     <= ST_BURST;
                        r_burst_cnt <= w_burst_len;
                    end
                    ST_BURST: begin
                        if (htrans == TR_SEQ) begin
                            r_burst_cnt <= r_burst_cnt - 4'd1;
                        end else begin
                            r_burst_cnt <= r_burst_cnt;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end else begin
            r_state <= r_state;
        end
    end

    assign hgrant    = r_grant;
    assign hmaster   = r_hmaster;
    assign hmastlock = r_mastlock;

    // BUSY only matters by not decrementing; named here for readability of the encoding.
    logic w_unused_busy;
    assign w_unused_busy = (htrans == TR_BUSY);
endmodule

// File: tb/tb_ahb_prio_arbiter.sv
// Scoreboard bench for ahb_prio_arbiter (4 masters, 2-bit priority); honours AHB_ARB_RR_EN.
module tb_ahb_prio_arbiter;
    logic       hclk;
    logic       hreset_n;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic [7:0] hprior;
    logic [1:0] htrans;
    logic [2:0] hburst;
    logic       hready;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    typedef struct packed {
        logic [3:0] grant;
        logic [1:0] master;
        logic       lock;
    } exp_t;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] tr;
        logic [2:0] bu;
        logic       rdy;
        logic [3:0] g;
    } stim_t;

    exp_t sb[$];
    exp_t prev_e;
    int   n_checks;
    int   n_fail;

    ahb_prio_arbiter #(.MAS_NUM(4), .PRIO_W(2)) dut (
        .hclk(hclk), .hreset_n(hreset_n), .hbusreq(hbusreq), .hlock(hlock),
        .hprior(hprior), .htrans(htrans), .hburst(hburst), .hready(hready),
        .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic do_reset();
        hreset_n = 1'b0;
        hbusreq = 4'b0000; hlock = 4'b0000; htrans = 2'd0; hburst = 3'd0; hready = 1'b1;
        repeat (2) @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        prev_e = '{grant: 4'b0001, master: 2'd0, lock: 1'b0};
        sb.delete();
    endtask

    // Drive one cycle and push what the outputs must be after the edge.
    task automatic step(input stim_t s);
        exp_t e;
        logic [1:0] own;
        hbusreq = s.req; hlock = s.lock; htrans = s.tr; hburst = s.bu; hready = s.rdy;
        own = idx_of(prev_e.grant);
        if (s.rdy) e = '{grant: s.g, master: own, lock: s.lock[own]};
        else       e = prev_e;
        sb.push_back(e);
        prev_e = e;
        @(posedge hclk);
        #1;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        hreset_n = 1'b0;
        hbusreq = 4'b1111; hready = 1'b1; hprior = 8'hFF;
        repeat (2) @(posedge hclk);
        #1;
        n_checks += 3;
        if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant got %b want 0001", hgrant); end
        if (hmaster !== 2'd0)   begin n_fail++; $display("FAIL reset_master got %0d want 0", hmaster); end
        if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_lock got %b want 0", hmastlock); end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s = '{req: 4'b0000, lock: 4'b0000, tr: 2'd0, bu: 3'd0, rdy: 1'b1, g: 4'b0001};
            step(s);
            e = sb.pop_front();
            n_checks += 3;
            if (hgrant !== e.grant)    begin n_fail++; $display("FAIL idle_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master)  begin n_fail++; $display("FAIL idle_master[%0d] got %0d want %0d", i, hmaster, e.master); end
            if (hmastlock !== e.lock)  begin n_fail++; $display("FAIL idle_lock[%0d] got %b want %b", i, hmastlock, e.lock); end
        end
    endtask

    task automatic test_priority();
        stim_t tbl [3];
        exp_t  e;
        do_reset();
        hprior = {2'd0, 2'd3, 2'd1, 2'd0};
        tbl = '{'{4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100},
                '{4'b0110, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0100},
                '{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001}};
        for (int i = 0; i < 3; i++) begin
            step(tbl[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (hgrant !== e.grant)    begin n_fail++; $display("FAIL prio_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master)  begin n_fail++; $display("FAIL prio_master[%0d] got %0d want %0d", i, hmaster, e.master); end
            if (hmastlock !== e.lock)  begin n_fail++; $display("FAIL prio_lock[%0d] got %b want %b", i, hmastlock, e.lock); end
        end
    endtask

    task automatic test_burst();
        stim_t tbl [15];
        stim_t s;
        exp_t  e;
        do_reset();
        hprior = {2'd3, 2'd0, 2'd1, 2'd0};
        tbl = '{'{4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd2, 3'd3, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd1, 3'd3, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd3, 3'd3, 1'b0, 4'b0010},
                '{4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd3, 3'd3, 1'b1, 4'b1000},
                '{4'b1000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b1000},
                '{4'b1000, 4'b0000, 2'd2, 3'd2, 1'b1, 4'b1000},
                '{4'b0000, 4'b0000, 2'd3, 3'd2, 1'b1, 4'b1000},
                '{4'b0000, 4'b0000, 2'd3, 3'd2, 1'b1, 4'b1000},
                '{4'b0000, 4'b0000, 2'd3, 3'd2, 1'b1, 4'b0001},
                '{4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd2, 3'd7, 1'b1, 4'b0010},
                '{4'b1010, 4'b0000, 2'd3, 3'd7, 1'b1, 4'b0010}};
        for (int i = 0; i < 15; i++) begin
            step(tbl[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (hgrant !== e.grant)    begin n_fail++; $display("FAIL burst_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master)  begin n_fail++; $display("FAIL burst_master[%0d] got %0d want %0d", i, hmaster, e.master); end
            if (hmastlock !== e.lock)  begin n_fail++; $display("FAIL burst_lock[%0d] got %b want %b", i, hmastlock, e.lock); end
        end
        // Reset in the middle of the INCR16; nothing of it may survive.
        hreset_n = 1'b0;
        #2;
        n_checks += 2;
        if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL midburst_rst_grant got %b want 0001", hgrant); end
        if (hmaster !== 2'd0)   begin n_fail++; $display("FAIL midburst_rst_master got %0d want 0", hmaster); end
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        prev_e = '{grant: 4'b0001, master: 2'd0, lock: 1'b0};
        s = '{req: 4'b1010, lock: 4'b0000, tr: 2'd3, bu: 3'd7, rdy: 1'b1, g: 4'b1000};
        step(s);
        e = sb.pop_front();
        n_checks += 2;
        if (hgrant !== e.grant)   begin n_fail++; $display("FAIL post_rst_grant got %b want %b", hgrant, e.grant); end
        if (hmaster !== e.master) begin n_fail++; $display("FAIL post_rst_master got %0d want %0d", hmaster, e.master); end
    endtask

    task automatic test_early_term();
        stim_t tbl [5];
        exp_t  e;
        do_reset();
        hprior = {2'd0, 2'd2, 2'd1, 2'd0};
        tbl = '{'{4'b0010, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0010},
                '{4'b0110, 4'b0000, 2'd2, 3'd5, 1'b1, 4'b0010},
                '{4'b0110, 4'b0000, 2'd3, 3'd5, 1'b1, 4'b0010},
                '{4'b0110, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0100},
                '{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001}};
        for (int i = 0; i < 5; i++) begin
            step(tbl[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (hgrant !== e.grant)    begin n_fail++; $display("FAIL early_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master)  begin n_fail++; $display("FAIL early_master[%0d] got %0d want %0d", i, hmaster, e.master); end
            if (hmastlock !== e.lock)  begin n_fail++; $display("FAIL early_lock[%0d] got %b want %b", i, hmastlock, e.lock); end
        end
    endtask

    task automatic test_lock();
        stim_t tbl [6];
        exp_t  e;
        do_reset();
        hprior = {2'd0, 2'd1, 2'd0, 2'd3};
        tbl = '{'{4'b0100, 4'b0100, 2'd0, 3'd0, 1'b1, 4'b0100},
                '{4'b0101, 4'b0100, 2'd2, 3'd0, 1'b1, 4'b0100},
                '{4'b0101, 4'b0100, 2'd2, 3'd0, 1'b1, 4'b0100},
                '{4'b0101, 4'b0100, 2'd2, 3'd0, 1'b0, 4'b0100},
                '{4'b0101, 4'b0000, 2'd2, 3'd0, 1'b1, 4'b0001},
                '{4'b0000, 4'b0000, 2'd0, 3'd0, 1'b1, 4'b0001}};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i]);
            e = sb.pop_front();
            n_checks += 3;
            if (hgrant !== e.grant)    begin n_fail++; $display("FAIL lock_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master)  begin n_fail++; $display("FAIL lock_master[%0d] got %0d want %0d", i, hmaster, e.master); end
            if (hmastlock !== e.lock)  begin n_fail++; $display("FAIL lock_mastlock[%0d] got %b want %b", i, hmastlock, e.lock); end
        end
    endtask

    task automatic test_ties();
        logic [3:0] rot [5];
        stim_t s;
        exp_t  e;
        do_reset();
        hprior = {2'd1, 2'd1, 2'd1, 2'd1};
`ifdef AHB_ARB_RR_EN
        rot = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
`else
        rot = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
        for (int i = 0; i < 5; i++) begin
            s = '{req: 4'b1111, lock: 4'b0000, tr: 2'd2, bu: 3'd1, rdy: 1'b1, g: rot[i]};
            step(s);
            e = sb.pop_front();
            n_checks += 2;
            if (hgrant !== e.grant)   begin n_fail++; $display("FAIL tie_grant[%0d] got %b want %b", i, hgrant, e.grant); end
            if (hmaster !== e.master) begin n_fail++; $display("FAIL tie_master[%0d] got %0d want %0d", i, hmaster, e.master); end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        hreset_n = 1'b0;
        hbusreq = 4'b0000; hlock = 4'b0000; hprior = 8'h00;
        htrans = 2'd0; hburst = 3'd0; hready = 1'b1;
        prev_e = '{grant: 4'b0001, master: 2'd0, lock: 1'b0};
        test_reset();
        test_priority();
        test_burst();
        test_early_term();
        test_lock();
        test_ties();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_prio_arbiter.md
AHB_PRIO_ARBITER -- requirements
Module: ahb_prio_arbiter

Interface
REQ-001 The block SHALL have parameter MAS_NUM, default 4, number of bus masters (2..16).
REQ-002 The block SHALL have parameter PRIO_W, default 2, width of each master's priority field.
REQ-003 The block SHALL have localparam IDX_W = $clog2(MAS_NUM), the master-index width.
REQ-004 The block SHALL have port hclk  in  1  bus clock; all state updates on its rising edge.
REQ-005 The block SHALL have port hreset_n  in  1  reset; one clock, asynchronous assert, active-low.
REQ-006 The block SHALL have port hbusreq  in  MAS_NUM  per-master bus request.
REQ-007 The block SHALL have port hlock  in  MAS_NUM  per-master locked-transfer request.
REQ-008 The block SHALL have port hprior  in  MAS_NUM*PRIO_W  per-master priority, master i at [i*PRIO_W +: PRIO_W]; larger value wins.
REQ-009 The block SHALL have port htrans  in  2  transfer type of the current address-phase owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-010 The block SHALL have port hburst  in  3  burst type of the current owner (SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7).
REQ-011 The block SHALL have port hready  in  1  bus-wide transfer-done.
REQ-012 The block SHALL have port hgrant  out  MAS_NUM  one-hot grant, registered.
REQ-013 The block SHALL have port hmaster  out  IDX_W  index of the current address-phase owner, registered.
REQ-014 The block SHALL have port hmastlock  out  1  current address phase is locked, registered.

Function
REQ-015 hgrant SHALL always be one-hot; hgrant and hmaster SHALL change only on an edge with hready=1.
REQ-016 On every edge with hready=1, hmaster SHALL load the index of the hgrant bit held before that edge, and hmastlock SHALL load hlock of that master.
REQ-017 FSM states SHALL be PARK, GRANT, BURST and LOCKED; arbitration SHALL be open only in PARK, in GRANT, and on an edge that leaves BURST.
REQ-018 In an open arbitration with hready=1, the winner SHALL be the requester with the highest hprior; ties SHALL be resolved per REQ-031/032; hgrant SHALL load the winner's one-hot, state SHALL become GRANT.
REQ-019 In an open arbitration with hready=1 and hbusreq=0, hgrant SHALL park on master 0 and state SHALL become PARK.
REQ-020 In GRANT with hready=1, htrans=NONSEQ and hburst in {WRAP4,INCR4}, burst_cnt SHALL load 3, state SHALL become BURST; 8-beat bursts SHALL load 7; 16-beat bursts SHALL load 15.
REQ-021 SINGLE and INCR bursts SHALL NOT enter BURST; INCR SHALL be re-arbitrated at any hready=1 edge.
REQ-022 In BURST, burst_cnt SHALL decrement on each edge with hready=1 and htrans=SEQ; htrans=BUSY SHALL hold the count.
REQ-023 In BURST, the edge with hready=1, htrans=SEQ and burst_cnt=1 SHALL be an open arbitration (handover after the last beat's address).
REQ-024 In BURST, htrans=IDLE or NONSEQ with hready=1 (early termination) SHALL clear burst_cnt and be an open arbitration.
REQ-025 hlock=1 on the granted master at an hready=1 edge SHALL move state to LOCKED and keep hgrant unchanged, overriding REQ-018 and REQ-023.
REQ-026 In LOCKED, hgrant SHALL be held until an hready=1 edge with hlock of the granted master 0, which SHALL be an open arbitration.
REQ-027 With hready=0, all state, hgrant, hmaster, hmastlock and burst_cnt SHALL hold.
REQ-028 The granted master dropping hbusreq mid-burst SHALL NOT shorten the burst.

Reset
REQ-029 While hreset_n=0: hgrant=1 (master 0), hmaster=0, hmastlock=0, state=PARK, burst_cnt=0, rr_ptr=0.
REQ-030 The first hready=1 edge after release SHALL perform an open arbitration; reset asserted mid-burst or mid-lock SHALL abandon it with no residual state.

Configuration
REQ-031 With macro AHB_ARB_RR_EN defined, priority ties SHALL resolve round-robin: the first tied requester at index > rr_ptr (wrapping) wins, and rr_ptr SHALL load the winner index on each grant.
REQ-032 Without AHB_ARB_RR_EN, ties SHALL resolve to the lowest index and rr_ptr SHALL not exist.

Verification
REQ-033 Reset, hbusreq=0, hready=1 -> hgrant=0001, hmaster=0, hmastlock=0 every cycle.
REQ-034 hbusreq=0110, hprior m1=1 m2=3 -> hgrant=0100 after one edge, hmaster=2 after the next.
REQ-035 m1 owns, NONSEQ INCR4, m3 requests at higher priority -> hgrant stays 0010 through 3 SEQ beats, becomes 1000 on the 4th beat edge; BUSY or hready=0 stretches it.
REQ-036 m1 INCR8 terminated by NONSEQ after 2 beats while m2 requests -> hgrant=0100 on that edge.
REQ-037 m2 hlock=1, m0 requests at priority 3 -> hgrant=0100, hmastlock=1 until hlock drops, then 0001.
REQ-038 AHB_ARB_RR_EN, hbusreq=1111, equal priorities, INCR traffic -> grants rotate 1,2,3,0; without macro -> grant stays 0001.
